axi4s_video_framer: RTL and testbench

//   Downstream of the quad-to-single pixel FIFO. Takes its flat 1-pixel/beat AXI4-Stream and adds
//   AXI4-Stream video framing: tuser on the first pixel of a frame (SOF), tlast on the last pixel
//   of every line (EOL). Uses per-frame width/height counters. A 2-entry skid buffer gives full

---
 rtl/axi4s_video_framer.sv | 225 ++++++++++++++++++++++
 tb/tb_axi4s_video_framer.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4s_video_framer.sv
// ---------------------------------------------------------------------------
// axi4s_video_framer
//
// Sits behind the quad-to-single pixel FIFO and turns its flat one-pixel-per-
// beat AXI4-Stream into an AXI4-Stream video stream.
//   * tuser marks the first pixel of a frame (start of frame).
//   * tlast marks the last pixel of every line (end of line).
// The frame geometry is captured once, at frame start, into width/height
// registers, and per-frame X/Y counters tag each accepted pixel. A two-entry
// skid buffer lets s_axis_tready come straight from a flop while still
// sustaining one pixel per clock.
//
// Ports
//   clk            in   1           clock, rising edge
//   rst_n          in   1           synchronous, active-low reset
//   enable         in   1           allow a new frame to start
//   cfg_width      in   XW          pixels per line, sampled at frame start
//   cfg_height     in   YW          lines per frame, sampled at frame start
//   s_axis_tdata   in   DATA_WIDTH  pixel from the upstream FIFO
//   s_axis_tvalid  in   1           upstream valid
//   s_axis_tready  out  1           framer ready (registered)
//   m_axis_tdata   out  DATA_WIDTH  framed pixel
//   m_axis_tvalid  out  1           output valid
//   m_axis_tready  in   1           sink ready
//   m_axis_tuser   out  1           start of frame, pixel (0,0) only
//   m_axis_tlast   out  1           end of line, pixel x == width-1
//   busy           out  1           a frame is in progress (RUN or DRAIN)
//   frame_done     out  1           one-cycle pulse after a frame's last pixel leaves
//   cfg_err        out  1           one-cycle pulse per rejected frame-start attempt
//   frame_cnt      out  16          completed frames, wraps 16'hFFFF -> 0
// ---------------------------------------------------------------------------
module axi4s_video_framer #(
  parameter int DATA_WIDTH = 24,
  parameter int MAX_WIDTH  = 4096,
  parameter int MAX_HEIGHT = 4096,
  parameter int XW         = $clog2(MAX_WIDTH + 1),
  parameter int YW         = $clog2(MAX_HEIGHT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [XW-1:0]         cfg_width,
  input  logic [YW-1:0]         cfg_height,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  cfg_err,
  output logic [15:0]           frame_cnt
);

  // A skid entry carries the pixel together with its two framing tags.
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [XW-1:0] W_MAX = XW'(MAX_WIDTH);
  localparam logic [YW-1:0] H_MAX = YW'(MAX_HEIGHT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [EW-1:0]   entry0;
  logic [EW-1:0]   entry1;
  logic [EW-1:0]   in_entry;
  logic [1:0]      count;
  logic [1:0]      count_next;
  logic            push;
  logic            pop;
  logic            wr_hi;
  logic            cfg_ok;
  logic            frame_start;
  logic            frame_end;

  logic [XW-1:0]   w_lat;
  logic [XW-1:0]   w_last;
  logic [XW-1:0]   x;
  logic [YW-1:0]   h_lat;
  logic [YW-1:0]   h_last;
  logic [YW-1:0]   y;
  logic            tag_user;
  logic            tag_last;
  logic [15:0]     frame_count;

  // Handshakes. s_axis_tready is only ever high in RUN, so a push always
  // belongs to the frame currently being counted.
  assign push = s_axis_tvalid & s_axis_tready;
  assign pop  = m_axis_tvalid & m_axis_tready;

  // entry0 is the head of the skid buffer and drives the output directly.
  assign m_axis_tvalid = (count != 2'd0);
  assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = entry0;

  assign busy      = (state != IDLE);
  assign frame_cnt = frame_count;

  assign cfg_ok = (cfg_width != '0) && (cfg_width <= W_MAX) &&
                  (cfg_height != '0) && (cfg_height <= H_MAX);
  assign frame_start = (state == IDLE) && enable && cfg_ok;

  assign w_last   = w_lat - XW'(1);
  assign h_last   = h_lat - YW'(1);
  assign tag_user = (x == '0) && (y == '0);
  assign tag_last = (x == w_last);
  assign in_entry = {tag_last, tag_user, s_axis_tdata};

  // In DRAIN nothing is pushed, so the frame's last pixel is the only one
  // left once the buffer holds a single entry; its pop ends the frame.
  assign frame_end = (state == DRAIN) && pop && (count == 2'd1);

  // A push lands in the slot behind whatever remains after this cycle's pop.
  assign wr_hi = (count == 2'd2) || ((count == 2'd1) && !pop);

  // Skid occupancy after this cycle's push and pop.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (pop && !push) begin
      count_next = count - 2'd1;
    end
  end

  // Frame sequencing: wait for a legal start, count pixels in, then wait for
  // the last tagged pixel to leave before allowing the next frame.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (push && tag_last && (y == h_last)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_end) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register plus the registered status outputs. s_axis_tready is
  // computed one cycle ahead from the next state and next occupancy, so the
  // upstream never sees a combinational path back from m_axis_tready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      s_axis_tready <= 1'b0;
      frame_done    <= 1'b0;
      cfg_err       <= 1'b0;
      frame_count   <= 16'd0;
    end else begin
      state         <= state_next;
      s_axis_tready <= (state_next == RUN) && (count_next != 2'd2);
      frame_done    <= frame_end;
      cfg_err       <= (state == IDLE) && enable && !cfg_ok;
      if (frame_end) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Two-entry skid buffer. On a pop with both entries full the second entry
  // moves to the head; a simultaneous push then refills the second slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      count <= count_next;
      if (pop && (count == 2'd2)) begin
        entry0 <= entry1;
      end
      if (push) begin
        if (wr_hi) begin
          entry1 <= in_entry;
        end else begin
          entry0 <= in_entry;
        end
      end
    end
  end

  // Geometry latch and pixel position counters. Width and height are only
  // captured at frame start, so cfg_* may change freely mid-frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_lat <= '0;
      h_lat <= '0;
      x     <= '0;
      y     <= '0;
    end else if (frame_start) begin
      w_lat <= cfg_width;
      h_lat <= cfg_height;
      x     <= '0;
      y     <= '0;
    end else if (push) begin
      if (tag_last) begin
        x <= '0;
        y <= (y == h_last) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi4s_video_framer.sv
// ---------------------------------------------------------------------------
// tb_axi4s_video_framer
//
// Directed bench for axi4s_video_framer. Each test task drives one scenario
// and compares the observed framing against hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_axi4s_video_framer;

  localparam int XW = 13;
  localparam int YW = 13;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [XW-1:0] cfg_width;
  logic [YW-1:0] cfg_height;
  logic [23:0]   s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [23:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          busy;
  logic          frame_done;
  logic          cfg_err;
  logic [15:0]   frame_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Capture of the most recent run_frame call.
  logic [23:0] cap_data [16];
  logic        cap_user [16];
  logic        cap_last [16];
  int          n_beats;
  int          first_beat_cyc;
  int          last_beat_cyc;
  int          done_cyc;
  int          done_pulses;
  int          hold_err;
  int          trdy_err;
  bit          timed_out;

  axi4s_video_framer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .cfg_width     (cfg_width),
    .cfg_height    (cfg_height),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .frame_done    (frame_done),
    .cfg_err       (cfg_err),
    .frame_cnt     (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Streams n_pix pixels (base, base+1, ...) into the framer and records
  // every output beat. stall selects the sink ready pattern 1,0,0,1.
  // keep_en leaves enable high after the frame starts.
  task automatic run_frame(input int n_pix, input logic [23:0] base,
                           input bit stall, input bit keep_en);
    int src_idx;
    int cyc;
    int occ;
    bit held;
    logic [25:0] held_val;
    src_idx = 0;
    cyc = 0;
    occ = 0;
    held = 0;
    held_val = '0;
    n_beats = 0;
    first_beat_cyc = -1;
    last_beat_cyc = -1;
    done_cyc = -1;
    done_pulses = 0;
    hold_err = 0;
    trdy_err = 0;
    timed_out = 0;
    for (int i = 0; i < 16; i++) begin
      cap_data[i] = 'x;
      cap_user[i] = 1'bx;
      cap_last[i] = 1'bx;
    end
    enable = 1'b1;
    while (!(done_pulses > 0 && cyc >= done_cyc + 3)) begin
      if (cyc >= 200) begin
        timed_out = 1;
        break;
      end
      s_axis_tvalid = (src_idx < n_pix);
      s_axis_tdata  = base + 24'(src_idx);
      m_axis_tready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      @(negedge clk);
      if (held && (!m_axis_tvalid ||
                   {m_axis_tlast, m_axis_tuser, m_axis_tdata} !== held_val)) begin
        hold_err++;
      end
      held = m_axis_tvalid && !m_axis_tready;
      held_val = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
      if (busy && src_idx < n_pix && s_axis_tready !== (occ < 2)) begin
        trdy_err++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (n_beats < 16) begin
          cap_data[n_beats] = m_axis_tdata;
          cap_user[n_beats] = m_axis_tuser;
          cap_last[n_beats] = m_axis_tlast;
        end
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        n_beats++;
        occ--;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        src_idx++;
        occ++;
      end
      if (frame_done) begin
        done_pulses++;
        done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (busy && !keep_en) enable = 1'b0;
      cyc++;
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  // Reset leaves every output low.
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, s_axis_tready, busy,
         frame_done, cfg_err} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b, want 0000000",
               {m_axis_tvalid, m_axis_tuser, m_axis_tlast, s_axis_tready, busy,
                frame_done, cfg_err});
    end
    vectors++;
    if (m_axis_tdata !== 24'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_tdata: got %h, want 000000", m_axis_tdata);
    end
    vectors++;
    if (frame_cnt !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_frame_cnt: got %h, want 0000", frame_cnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // 4x2 frame, source and sink always ready.
  task automatic test_basic_frame();
    cfg_width  = 13'd4;
    cfg_height = 13'd2;
    run_frame(8, 24'h000001, 1'b0, 1'b0);
    vectors++;
    if (timed_out || n_beats !== 8) begin
      miscompares++;
      $display("[TB] FAIL t1_beats: got %0d (timeout=%0d), want 8", n_beats, timed_out);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (cap_data[i] !== 24'(i + 1) || cap_user[i] !== (i == 0) ||
          cap_last[i] !== (i == 3 || i == 7)) begin
        miscompares++;
        $display("[TB] FAIL t1_beat%0d: got data=%h user=%b last=%b, want data=%h user=%b last=%b",
                 i, cap_data[i], cap_user[i], cap_last[i], 24'(i + 1), (i == 0), (i == 3 || i == 7));
      end
    end
    vectors++;
    if (last_beat_cyc - first_beat_cyc !== 7) begin
      miscompares++;
      $display("[TB] FAIL t1_throughput: got span %0d cycles, want 7", last_beat_cyc - first_beat_cyc);
    end
    vectors++;
    if (done_pulses !== 1 || done_cyc !== last_beat_cyc + 1) begin
      miscompares++;
      $display("[TB] FAIL t1_frame_done: got %0d pulses at cycle %0d, want 1 at %0d",
               done_pulses, done_cyc, last_beat_cyc + 1);
    end
    vectors++;
    if (frame_cnt !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL t1_frame_cnt: got %0d, want 1", frame_cnt);
    end
    vectors++;
    if (trdy_err !== 0) begin
      miscompares++;
      $display("[TB] FAIL t1_s_tready: got %0d bad cycles, want 0", trdy_err);
    end
  endtask

  // Same frame with the sink ready pattern 1,0,0,1.
  task automatic test_backpressure();
    cfg_width  = 13'd4;
    cfg_height = 13'd2;
    run_frame(8, 24'h000001, 1'b1, 1'b0);
    vectors++;
    if (timed_out || n_beats !== 8) begin
      miscompares++;
      $display("[TB] FAIL t2_beats: got %0d (timeout=%0d), want 8", n_beats, timed_out);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (cap_data[i] !== 24'(i + 1) || cap_user[i] !== (i == 0) ||
          cap_last[i] !== (i == 3 || i == 7)) begin
        miscompares++;
        $display("[TB] FAIL t2_beat%0d: got data=%h user=%b last=%b, want data=%h user=%b last=%b",
                 i, cap_data[i], cap_user[i], cap_last[i], 24'(i + 1), (i == 0), (i == 3 || i == 7));
      end
    end
    vectors++;
    if (hold_err !== 0) begin
      miscompares++;
      $display("[TB] FAIL t2_hold: got %0d unstable stalled cycles, want 0", hold_err);
    end
    vectors++;
    if (trdy_err !== 0) begin
      miscompares++;
      $display("[TB] FAIL t2_s_tready: got %0d bad cycles, want 0", trdy_err);
    end
    vectors++;
    if (done_pulses !== 1 || frame_cnt !== 16'd2) begin
      miscompares++;
      $display("[TB] FAIL t2_done: got pulses=%0d cnt=%0d, want pulses=1 cnt=2", done_pulses, frame_cnt);
    end
  endtask

  // 1x1 frame: the single pixel is both start of frame and end of line.
  task automatic test_single_pixel();
    cfg_width  = 13'd1;
    cfg_height = 13'd1;
    run_frame(1, 24'hABCDEF, 1'b0, 1'b0);
    vectors++;
    if (timed_out || n_beats !== 1 || cap_data[0] !== 24'hABCDEF ||
        cap_user[0] !== 1'b1 || cap_last[0] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL t3_beat: got n=%0d data=%h user=%b last=%b, want n=1 data=abcdef user=1 last=1",
               n_beats, cap_data[0], cap_user[0], cap_last[0]);
    end
    vectors++;
    if (done_pulses !== 1 || frame_cnt !== 16'd3) begin
      miscompares++;
      $display("[TB] FAIL t3_done: got pulses=%0d cnt=%0d, want pulses=1 cnt=3", done_pulses, frame_cnt);
    end
  endtask

  // Illegal geometries are rejected every cycle while enable is high.
  task automatic test_cfg_error();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 24'h123456;
    enable        = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cfg_width  = (k == 0) ? 13'd0 : 13'd4;
      cfg_height = (k == 0) ? 13'd2 : 13'd4097;
      @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        vectors++;
        if ({cfg_err, s_axis_tready, busy} !== 3'b100) begin
          miscompares++;
          $display("[TB] FAIL t4_cfg%0d_cyc%0d: got err/tready/busy=%b, want 100",
                   k, c, {cfg_err, s_axis_tready, busy});
        end
        @(posedge clk);
        #1;
      end
    end
    enable     = 1'b0;
    cfg_width  = 13'd4;
    cfg_height = 13'd2;
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (cfg_err !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd3) begin
      miscompares++;
      $display("[TB] FAIL t4_after: got err=%b busy=%b cnt=%0d, want err=0 busy=0 cnt=3",
               cfg_err, busy, frame_cnt);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  // Reset after three pixels discards the frame; the next frame is clean.
  task automatic test_reset_mid_frame();
    int src;
    int cyc;
    int done_seen;
    cfg_width     = 13'd4;
    cfg_height    = 13'd2;
    enable        = 1'b1;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    src = 0;
    cyc = 0;
    done_seen = 0;
    while (src < 3 && cyc < 50) begin
      s_axis_tdata = 24'(src + 1);
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready) src++;
      @(posedge clk);
      #1;
      if (busy) enable = 1'b0;
      cyc++;
    end
    vectors++;
    if (src !== 3) begin
      miscompares++;
      $display("[TB] FAIL t5_feed: got %0d pixels accepted, want 3", src);
    end
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, s_axis_tready, busy,
         frame_done, cfg_err} !== 7'b0 || m_axis_tdata !== 24'h0 || frame_cnt !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL t5_reset_outputs: got ctrl=%b tdata=%h cnt=%h, want all 0",
               {m_axis_tvalid, m_axis_tuser, m_axis_tlast, s_axis_tready, busy,
                frame_done, cfg_err}, m_axis_tdata, frame_cnt);
    end
    for (int c = 0; c < 5; c++) begin
      if (frame_done) done_seen++;
      @(negedge clk);
    end
    vectors++;
    if (done_seen !== 0) begin
      miscompares++;
      $display("[TB] FAIL t5_no_done: got %0d frame_done cycles, want 0", done_seen);
    end
    @(posedge clk);
    #1;
    run_frame(8, 24'h000001, 1'b0, 1'b0);
    vectors++;
    if (timed_out || n_beats !== 8 || cap_user[0] !== 1'b1 || cap_data[0] !== 24'h1 ||
        cap_last[3] !== 1'b1 || cap_data[7] !== 24'h8) begin
      miscompares++;
      $display("[TB] FAIL t5_rerun: got n=%0d d0=%h u0=%b l3=%b d7=%h, want n=8 d0=000001 u0=1 l3=1 d7=000008",
               n_beats, cap_data[0], cap_user[0], cap_last[3], cap_data[7]);
    end
    vectors++;
    if (frame_cnt !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL t5_frame_cnt: got %0d, want 1", frame_cnt);
    end
  endtask

  // Back-to-back 2x2 frames with enable held; frame_cnt wraps to zero.
  task automatic test_back_to_back();
    enable = 1'b0;
    force dut.frame_count = 16'hFFFE;
    @(negedge clk);
    release dut.frame_count;
    @(posedge clk);
    #1;
    cfg_width  = 13'd2;
    cfg_height = 13'd2;
    for (int f = 0; f < 2; f++) begin
      run_frame(4, (f == 0) ? 24'h000100 : 24'h000200, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (cap_data[i] !== ((f == 0) ? 24'h000100 : 24'h000200) + 24'(i) ||
            cap_user[i] !== (i == 0) || cap_last[i] !== (i == 1 || i == 3)) begin
          miscompares++;
          $display("[TB] FAIL t6_f%0d_beat%0d: got data=%h user=%b last=%b, want user=%b last=%b",
                   f, i, cap_data[i], cap_user[i], cap_last[i], (i == 0), (i == 1 || i == 3));
        end
      end
      vectors++;
      if (timed_out || done_pulses !== 1 ||
          frame_cnt !== ((f == 0) ? 16'hFFFF : 16'h0000)) begin
        miscompares++;
        $display("[TB] FAIL t6_f%0d_cnt: got cnt=%h pulses=%0d timeout=%0d, want cnt=%h pulses=1",
                 f, frame_cnt, done_pulses, timed_out, (f == 0) ? 16'hFFFF : 16'h0000);
      end
    end
    enable = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    enable        = 1'b0;
    cfg_width     = '0;
    cfg_height    = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_single_pixel();
    test_cfg_error();
    test_reset_mid_frame();
    test_back_to_back();
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
